mdp3_book_parser: RTL

- Parses MDP3 incremental-refresh-book packets from a 64-bit word stream.
- Accepts a packet header followed by a variable-length repeating group of book entries.
- Emits one decoded, endian-corrected entry per output handshake.
- Sits between the packet framer and the order book. It supersedes the single-entry fixed-format parser with backpressure, variable entry counts, error handling and optional sequence-gap detection.

---
 rtl/mdp3_pkg.sv | 72 +++++++
 rtl/mdp3_seq_checker.sv | 31 +++
 rtl/mdp3_book_parser.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mdp3_pkg.sv
// Shared types, field codes and byte-swap helpers for the MDP3 incremental-refresh-book parser.
package mdp3_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_ENT_A,
        ST_ENT_B,
        ST_ENT_C,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] ACT_NEW    = 2'd0;
    localparam logic [1:0] ACT_CHANGE = 2'd1;
    localparam logic [1:0] ACT_DELETE = 2'd2;

    localparam logic [1:0] ET_BID   = 2'd0;
    localparam logic [1:0] ET_OFFER = 2'd1;
    localparam logic [1:0] ET_OTHER = 2'd3;

    localparam logic [7:0] ET_CODE_BID   = 8'h30;
    localparam logic [7:0] ET_CODE_OFFER = 8'h31;

    typedef struct packed {
        logic [63:0] price;
        logic [31:0] quantity;
        logic [31:0] security_id;
        logic [31:0] rpt_seq;
        logic [7:0]  num_orders;
        logic [7:0]  price_level;
        logic [1:0]  action;
        logic [1:0]  entry_type;
        logic        last;
    } entry_t;

    function automatic logic [15:0] bswap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = v[8*(3-i) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] bswap64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(7-i) +: 8];
        return r;
    endfunction

    // Caller guarantees code <= 2; anything larger is rejected upstream.
    function automatic logic [1:0] decode_action(input logic [7:0] code);
        logic [1:0] r;
        case (code)
            8'd0:    r = ACT_NEW;
            8'd1:    r = ACT_CHANGE;
            default: r = ACT_DELETE;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] decode_entry_type(input logic [7:0] code);
        logic [1:0] r;
        case (code)
            ET_CODE_BID:   r = ET_BID;
            ET_CODE_OFFER: r = ET_OFFER;
            default:       r = ET_OTHER;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdp3_seq_checker.sv
// Tracks the expected MsgSeqNum across accepted headers and pulses seq_gap on a discontinuity.
module mdp3_seq_checker (
    input  logic        clk,
    input  logic        reset,
    input  logic        hdr_accept,
    input  logic [31:0] seq,
    output logic        seq_gap
);

    logic [31:0] expected_reg;
    logic        primed_reg;
    logic        gap_reg;

    // The first header after reset only seeds the expectation; +1 wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            expected_reg <= '0;
            primed_reg   <= 1'b0;
            gap_reg      <= 1'b0;
        end else begin
            gap_reg <= hdr_accept && primed_reg && (seq != expected_reg);
            if (hdr_accept) begin
                expected_reg <= seq + 32'd1;
                primed_reg   <= 1'b1;
            end
        end
    end

    assign seq_gap = gap_reg;

endmodule

// File: rtl/mdp3_book_parser.sv
// MDP3 incremental-refresh-book parser: header + N three-word entries in, one decoded entry per handshake out.
// Optional MsgSeqNum gap detection is built when MDP3_SEQ_CHECK_EN is defined.
module mdp3_book_parser
    import mdp3_pkg::*;
#(
    parameter int MAX_ENTRIES = 16,
    parameter int TEMPLATE_ID = 46
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_price,
    output logic [31:0] out_quantity,
    output logic [31:0] out_security_id,
    output logic [31:0] out_rpt_seq,
    output logic [7:0]  out_num_orders,
    output logic [7:0]  out_price_level,
    output logic [1:0]  out_action,
    output logic [1:0]  out_entry_type,
    output logic        out_last_entry,
    output logic        pkt_err,
    output logic [15:0] err_count,
    output logic        seq_gap
);

    localparam logic [7:0]  MAX_COUNT = 8'(MAX_ENTRIES);
    localparam logic [15:0] TEMPLATE  = 16'(TEMPLATE_ID);

    state_t      state_reg, state_next;
    logic [7:0]  remaining_reg, remaining_next;
    logic [63:0] price_reg;
    logic [31:0] quantity_reg;
    logic [31:0] security_id_reg;
    entry_t      out_reg, entry_next;
    logic        out_valid_reg;
    logic        pkt_err_reg, err_next;
    logic [15:0] err_count_reg;
    logic        accept;
    logic        load_entry;
    logic [15:0] hdr_template;
    logic [7:0]  hdr_count;
    logic [7:0]  action_byte;

    assign hdr_template = bswap16(in_data[31:16]);
    assign hdr_count    = in_data[15:8];
    assign action_byte  = in_data[47:40];

    // Entry words are only taken when the output register is free or draining this cycle.
    always_comb begin
        in_ready = 1'b1;
        if (state_reg == ST_ENT_A || state_reg == ST_ENT_B || state_reg == ST_ENT_C)
            in_ready = !out_valid_reg || out_ready;
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        entry_next             = '0;
        entry_next.price       = price_reg;
        entry_next.quantity    = quantity_reg;
        entry_next.security_id = security_id_reg;
        entry_next.rpt_seq     = bswap32(in_data[31:0]);
        entry_next.num_orders  = in_data[63:56];
        entry_next.price_level = in_data[55:48];
        entry_next.action      = decode_action(action_byte);
        entry_next.entry_type  = decode_entry_type(in_data[39:32]);
        entry_next.last        = (remaining_reg == 8'd1);
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        err_next       = 1'b0;
        load_entry     = 1'b0;
        if (accept) begin
            case (state_reg)
                ST_HDR: begin
                    if (hdr_template != TEMPLATE || hdr_count == 8'd0) begin
                        state_next = in_last ? ST_HDR : ST_DRAIN;
                    end else if (hdr_count > MAX_COUNT) begin
                        err_next   = 1'b1;
                        state_next = in_last ? ST_HDR : ST_DRAIN;
                    end else if (in_last) begin
                        err_next   = 1'b1;
                        state_next = ST_HDR;
                    end else begin
                        state_next     = ST_ENT_A;
                        remaining_next = hdr_count;
                    end
                end
                ST_ENT_A: begin
                    err_next   = in_last;
                    state_next = in_last ? ST_HDR : ST_ENT_B;
                end
                ST_ENT_B: begin
                    err_next   = in_last;
                    state_next = in_last ? ST_HDR : ST_ENT_C;
                end
                ST_ENT_C: begin
                    if (action_byte > 8'd2) begin
                        err_next   = 1'b1;
                        state_next = in_last ? ST_HDR : ST_DRAIN;
                    end else begin
                        load_entry     = 1'b1;
                        remaining_next = remaining_reg - 8'd1;
                        if (remaining_reg == 8'd1) begin
                            state_next = in_last ? ST_HDR : ST_DRAIN;
                        end else if (in_last) begin
                            err_next   = 1'b1;
                            state_next = ST_HDR;
                        end else begin
                            state_next = ST_ENT_A;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (in_last) state_next = ST_HDR;
                end
                default: state_next = ST_HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= ST_HDR;
            remaining_reg   <= '0;
            price_reg       <= '0;
            quantity_reg    <= '0;
            security_id_reg <= '0;
            out_reg         <= '0;
            out_valid_reg   <= 1'b0;
            pkt_err_reg     <= 1'b0;
            err_count_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            pkt_err_reg   <= err_next;
            if (err_next && err_count_reg != 16'hFFFF)
                err_count_reg <= err_count_reg + 16'd1;
            if (accept && state_reg == ST_ENT_A)
                price_reg <= bswap64(in_data);
            if (accept && state_reg == ST_ENT_B) begin
                quantity_reg    <= bswap32(in_data[63:32]);
                security_id_reg <= bswap32(in_data[31:0]);
            end
            if (load_entry) begin
                out_reg       <= entry_next;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid       = out_valid_reg;
    assign out_price       = out_reg.price;
    assign out_quantity    = out_reg.quantity;
    assign out_security_id = out_reg.security_id;
    assign out_rpt_seq     = out_reg.rpt_seq;
    assign out_num_orders  = out_reg.num_orders;
    assign out_price_level = out_reg.price_level;
    assign out_action      = out_reg.action;
    assign out_entry_type  = out_reg.entry_type;
    assign out_last_entry  = out_reg.last;
    assign pkt_err         = pkt_err_reg;
    assign err_count       = err_count_reg;

`ifdef MDP3_SEQ_CHECK_EN
    mdp3_seq_checker u_seq_checker (
        .clk        (clk),
        .reset      (reset),
        .hdr_accept (accept && state_reg == ST_HDR),
        .seq        (bswap32(in_data[63:32])),
        .seq_gap    (seq_gap)
    );
`else
    assign seq_gap = 1'b0;
`endif

endmodule
